// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and a
// constant-function log2 used to size the digit counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/h_adder.sv
// Single-bit half adder, the leaf cell of the ripple-carry chain.
module h_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/rc_adder.sv
// Combinational W-bit ripple-carry adder. Besides the carry-out it exposes
// the carry into the top bit so the caller can form signed overflow.
module rc_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // Each bit is a full adder made from two half adders; the carry for each
  // bit lives in its own generate scope so the chain is a plain net per bit.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic c_in;
    logic c_out;
    logic s1;
    logic c1;
    logic c2;

    if (i == 0) begin : g_first
      assign c_in = ci;
    end else begin : g_chain
      assign c_in = g_bit[i-1].c_out;
    end

    h_adder u_ha0 (.a(x[i]), .b(y[i]), .s(s1),   .c(c1));
    h_adder u_ha1 (.a(s1),   .b(c_in), .s(s[i]), .c(c2));

    assign c_out = c1 | c2;
  end

  assign co    = g_bit[W-1].c_out;
  assign c_msb = g_bit[W-1].c_in;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle carry-propagate adder: adds DIGIT bits per clock, so one
// WIDTH-bit add takes WIDTH/DIGIT cycles. start/ready/done handshake;
// sum, carry-out and signed overflow are held until the next result.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             step;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_nxt;

  // Next-state and handshake decode; the unused encoding behaves as IDLE.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        step = 1'b1;
        last = (cnt == LAST);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One digit of the add: low DIGIT bits of each operand plus the running carry.
  rc_adder #(.W(DIGIT)) u_digit (
    .x     (opa[DIGIT-1:0]),
    .y     (opb[DIGIT-1:0]),
    .ci    (carry),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // Result shift register: each new digit enters at the top. Only the upper
  // WIDTH-DIGIT bits need storing, since the newest digit comes straight from
  // the adder; with a single digit there is nothing to store at all.
  if (DIGIT == WIDTH) begin : g_no_res
    assign res_nxt = dig_s;
  end else begin : g_res
    logic [WIDTH-DIGIT-1:0] res;

    assign res_nxt = {dig_s, res};

    // Partial-result shift register, advanced once per processed digit.
    always_ff @(posedge clk) begin
      if (rst)       res <= '0;
      else if (step) res <= res_nxt[WIDTH-1:DIGIT];
    end
  end

  // Operand/carry shifting, digit counter and result output registers.
  // NOTE: all datapath registers are reset, so an add aborted by rst leaves
  // no stale operands or partial carry behind and the outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      opa   <= a;
      opb   <= b;
      carry <= cin;
    end else if (step) begin
      cnt   <= cnt + CW'(1);
      opa   <= opa >> DIGIT;
      opb   <= opb >> DIGIT;
      carry <= dig_co;
      if (last) begin
        sum  <= res_nxt;
        cout <= dig_co;
        ovf  <= dig_cmsb ^ dig_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Main instance is (8,2); extra
// instances (8,1), (8,8) and (16,4) share clock and reset for a random sweep.
module tb_serial_adder;

  localparam int NDUT = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NDUT-1:0] start;
  logic [15:0]     a_in [NDUT];
  logic [15:0]     b_in [NDUT];
  logic [NDUT-1:0] cin;

  wire [7:0]       sum0, sum1, sum2;
  wire [15:0]      sum3;
  wire [NDUT-1:0]  ready, cout, ovf, done;

  int   tests  = 0;
  int   failed = 0;
  res_t last_res [NDUT];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a_in[0][7:0]), .b(b_in[0][7:0]),
    .cin(cin[0]), .ready(ready[0]), .sum(sum0), .cout(cout[0]), .ovf(ovf[0]), .done(done[0]));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a_in[1][7:0]), .b(b_in[1][7:0]),
    .cin(cin[1]), .ready(ready[1]), .sum(sum1), .cout(cout[1]), .ovf(ovf[1]), .done(done[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d2 (
    .clk(clk), .rst(rst), .start(start[2]), .a(a_in[2][7:0]), .b(b_in[2][7:0]),
    .cin(cin[2]), .ready(ready[2]), .sum(sum2), .cout(cout[2]), .ovf(ovf[2]), .done(done[2]));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_d3 (
    .clk(clk), .rst(rst), .start(start[3]), .a(a_in[3]), .b(b_in[3]),
    .cin(cin[3]), .ready(ready[3]), .sum(sum3), .cout(cout[3]), .ovf(ovf[3]), .done(done[3]));

  function automatic int w_of(input int id);
    case (id)
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int n_of(input int id);
    case (id)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] sum_of(input int id);
    case (id)
      0:       return {8'h00, sum0};
      1:       return {8'h00, sum1};
      2:       return {8'h00, sum2};
      default: return sum3;
    endcase
  endfunction

  // Reference: plain integer addition, carry is the bit past the width,
  // overflow is "operands share a sign that the result does not".
  function automatic res_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic c);
    res_t        r;
    int unsigned m, t, sx, sy, ss;
    m      = (32'd1 << w) - 1;
    t      = (int'(x) & m) + (int'(y) & m) + int'(c);
    sx     = (int'(x) >> (w - 1)) & 1;
    sy     = (int'(y) >> (w - 1)) & 1;
    ss     = (t >> (w - 1)) & 1;
    r.sum  = 16'(t & m);
    r.cout = 1'((t >> w) & 1);
    r.ovf  = (sx == sy) && (ss != sx);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction on instance id, with latency, busy and hold checks.
  task automatic run_op(input int id, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input res_t exp, input string tag);
    int lat;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready[id] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready before start"}, 32'(ready[id]), 32'd1);
    start[id] = 1'b1;
    a_in[id]  = x;
    b_in[id]  = y;
    cin[id]   = c;
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the add in flight must ignore them.
    start[id] = 1'b0;
    a_in[id]  = 16'($urandom);
    b_in[id]  = 16'($urandom);
    cin[id]   = 1'($urandom);
    check({tag, " ready while busy"}, 32'(ready[id]), 32'd0);
    check({tag, " sum held while busy"}, 32'(sum_of(id)), 32'(last_res[id].sum));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done[id] && lat < 40);
    check({tag, " latency"}, 32'(lat), 32'(n_of(id)));
    check({tag, " sum"},  32'(sum_of(id)), 32'(exp.sum));
    check({tag, " cout"}, 32'(cout[id]), 32'(exp.cout));
    check({tag, " ovf"},  32'(ovf[id]), 32'(exp.ovf));
    last_res[id] = exp;
    @(posedge clk);
    #1;
    check({tag, " done one cycle"}, 32'(done[id]), 32'd0);
    check({tag, " ready after done"}, 32'(ready[id]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    res_t        r;
    res_t        q [$];
    int          prev_acc;
    int          guard;
    logic        saw_done;
    logic [15:0] x, y;
    logic        c;

    vecs = '{
      '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
      '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
      '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0}
    };

    rst   = 1'b1;
    start = '0;
    cin   = '0;
    for (int i = 0; i < NDUT; i++) begin
      a_in[i]     = '0;
      b_in[i]     = '0;
      last_res[i] = '0;
    end

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset sum",   32'(sum0), 32'h0);
    check("reset cout",  32'(cout[0]), 32'd0);
    check("reset ovf",   32'(ovf[0]), 32'd0);
    check("reset done",  32'(done[0]), 32'd0);
    check("reset ready", 32'(ready), 32'hF);

    // Directed vectors on the (8,2) instance.
    for (int i = 0; i < 7; i++) begin
      r.sum  = {8'h00, vecs[i].sum};
      r.cout = vecs[i].cout;
      r.ovf  = vecs[i].ovf;
      run_op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].cin, r,
             $sformatf("vec%0d", i));
    end

    // start held high while operands change every cycle: only values present
    // on IDLE edges are used, and accepts are N+2 edges apart.
    @(negedge clk);
    start[0] = 1'b1;
    prev_acc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc != 0) @(negedge clk);
      a_in[0] = {8'h00, 8'($urandom)};
      b_in[0] = {8'h00, 8'($urandom)};
      cin[0]  = 1'($urandom);
      if (ready[0]) begin
        q.push_back(model(8, a_in[0], b_in[0], cin[0]));
        if (prev_acc >= 0) check("held start accept spacing", 32'(cyc - prev_acc), 32'd6);
        prev_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (done[0]) begin
        check("held start result pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          r = q.pop_front();
          check("held start sum",  32'(sum0), 32'(r.sum));
          check("held start cout", 32'(cout[0]), 32'(r.cout));
          check("held start ovf",  32'(ovf[0]), 32'(r.ovf));
          last_res[0] = r;
        end
      end
    end
    @(negedge clk);
    start[0] = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 12) begin
      @(posedge clk);
      #1;
      guard++;
      if (done[0]) begin
        r = q.pop_front();
        check("held start drain sum", 32'(sum0), 32'(r.sum));
        last_res[0] = r;
      end
    end
    check("held start queue drained", 32'(q.size()), 32'd0);

    // Reset during the second RUN cycle aborts the add.
    run_op(0, 16'h0011, 16'h0022, 1'b0, model(8, 16'h0011, 16'h0022, 1'b0), "pre-abort");
    @(negedge clk);
    start[0] = 1'b1;
    a_in[0]  = 16'h0012;
    b_in[0]  = 16'h0034;
    cin[0]   = 1'b0;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort sum",   32'(sum0), 32'h0);
    check("abort ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done[0]) saw_done = 1'b1;
    end
    check("abort no done", 32'(saw_done), 32'd0);
    check("abort sum after", 32'(sum0), 32'h0);
    check("abort cout/ovf", 32'({cout[0], ovf[0]}), 32'd0);
    for (int i = 0; i < NDUT; i++) last_res[i] = '0;
    r.sum  = 16'h0002;
    r.cout = 1'b0;
    r.ovf  = 1'b0;
    run_op(0, 16'h0001, 16'h0001, 1'b0, r, "post-abort");

    // Random sweep on every configuration.
    for (int id = 0; id < NDUT; id++) begin
      for (int k = 0; k < 25; k++) begin
        x = 16'($urandom);
        y = 16'($urandom);
        c = 1'($urandom);
        if (w_of(id) == 8) begin
          x[15:8] = 8'h00;
          y[15:8] = 8'h00;
        end
        run_op(id, x, y, c, model(w_of(id), x, y, c), $sformatf("rand d%0d #%0d", id, k));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
